// File: rtl/imem_debug_loader_pkg.sv
// rtl/imem_debug_loader_pkg.sv - shared FSM state and error-code encodings for the imem debug loader
package imem_debug_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_VREAD,
    ST_FINISH,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_VERIFY   = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_e;

  localparam logic [31:0] WORD_STEP = 32'd4;

endpackage

// File: rtl/imem_debug_loader_packer.sv
// rtl/imem_debug_loader_packer.sv - packs bytes little-endian into a zero-padded 32-bit word
module imem_debug_loader_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_ready_o,
  output logic        last_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    last_d = last_q;
    if (clr_i) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
      last_d = 1'b0;
    end else if (take_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 2'd1;
      last_d               = last_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      last_q <= last_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = take_i && ((idx_q == 2'd3) || last_i);
  assign last_o       = last_q;

endmodule

// File: rtl/imem_debug_loader.sv
// rtl/imem_debug_loader.sv - byte stream to instruction-memory debug-port writer with optional readback verify
module imem_debug_loader
  import imem_debug_loader_pkg::*;
#(
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int VERIFY       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        debug_en,
  output logic [31:0] debug_addr,
  output logic [31:0] debug_data_in,
  output logic        debug_write_en,
  input  logic [31:0] debug_data_out,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d, error_q, error_d;
  err_e        err_code_q, err_code_d;
  logic [15:0] wc_q, wc_d;
  logic        hold_q, hold_d, busy_q, busy_d;
  logic [2:0]  lat_q, lat_d;
  logic        pk_clr, pk_take, pk_ready, pk_last;
  logic [31:0] pk_word;
  logic        overflow;

  assign in_ready = (state_q == ST_COLLECT);
  assign pk_take  = in_valid && in_ready;
  assign overflow = {2'b00, addr_q[31:2]} >= 32'(MEM_WORDS);

  imem_debug_loader_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (pk_clr),
    .take_i       (pk_take),
    .byte_i       (in_data),
    .last_i       (in_last),
    .word_o       (pk_word),
    .word_ready_o (pk_ready),
    .last_o       (pk_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    wc_d       = wc_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    lat_d      = lat_q;
    pk_clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = ERR_NONE;
        wc_d       = 16'd0;
        addr_d     = base_addr & ~32'd3;
        hold_d     = 1'b1;
        busy_d     = 1'b1;
        pk_clr     = 1'b1;
        state_d    = ST_COLLECT;
      end
      ST_COLLECT: if (pk_ready) state_d = ST_WRITE;
      ST_WRITE: begin
        if (overflow) begin
          error_d    = 1'b1;
          err_code_d = ERR_OVERFLOW;
          state_d    = ST_FAIL;
        end else begin
          if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
          if (VERIFY != 0) begin
            lat_d   = 3'd0;
            state_d = ST_VREAD;
          end else if (pk_last) begin
            state_d = ST_FINISH;
          end else begin
            addr_d  = addr_q + WORD_STEP;
            pk_clr  = 1'b1;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_VREAD: begin
        // debug_data_out reflects the address presented READ_LATENCY cycles earlier
        if (lat_q == 3'(READ_LATENCY)) begin
          if (debug_data_out != pk_word) begin
            error_d    = 1'b1;
            err_code_d = ERR_VERIFY;
            state_d    = ST_FAIL;
          end else if (pk_last) begin
            state_d = ST_FINISH;
          end else begin
            addr_d  = addr_q + WORD_STEP;
            pk_clr  = 1'b1;
            state_d = ST_COLLECT;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
      // cpu_hold intentionally left asserted so a corrupt image never runs
      ST_FAIL: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      wc_q       <= 16'd0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      lat_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      wc_q       <= wc_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      lat_q      <= lat_d;
    end
  end

  assign debug_en       = ((state_q == ST_WRITE) && !overflow) || (state_q == ST_VREAD);
  assign debug_write_en = (state_q == ST_WRITE) && !overflow;
  assign debug_addr     = debug_en ? addr_q : 32'd0;
  assign debug_data_in  = debug_en ? pk_word : 32'd0;
  assign cpu_hold       = hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_imem_debug_loader.sv
// tb/tb_imem_debug_loader.sv - directed self-checking bench for imem_debug_loader
module tb_imem_debug_loader;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [31:0] base_addr;
  logic [7:0]  in_data;
  logic        in_ready, debug_en, debug_write_en, cpu_hold, busy, done, error;
  logic [31:0] debug_addr, debug_data_in, debug_data_out;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  int vec = 0;
  int miscompares = 0;

  logic [31:0] mem [0:7];
  logic [31:0] rd_pipe [RL];
  logic        corrupt = 1'b0;
  int          acc = 0;
  logic [31:0] wa[$], wd[$];
  int          wacc[$];
  logic [7:0]  stim[$];

  always #5 clk = ~clk;

  imem_debug_loader #(.MEM_WORDS(4), .READ_LATENCY(RL), .VERIFY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .debug_en(debug_en), .debug_addr(debug_addr), .debug_data_in(debug_data_in),
    .debug_write_en(debug_write_en), .debug_data_out(debug_data_out),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .word_count(word_count)
  );

  // Memory model: write on strobe, RL-stage read pipeline, optional bit-0 corruption at 0x4
  always @(posedge clk) begin
    if (debug_en)
      rd_pipe[0] <= mem[debug_addr[4:2]] ^ {31'd0, (corrupt && debug_addr == 32'h4)};
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (debug_en && debug_write_en) mem[debug_addr[4:2]] <= debug_data_in;
  end
  assign debug_data_out = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (in_valid && in_ready) acc = acc + 1;
    if (debug_en && debug_write_en) begin
      wa.push_back(debug_addr);
      wd.push_back(debug_data_in);
      wacc.push_back(acc);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    acc = 0;
    wa.delete();
    wd.delete();
    wacc.delete();
  endtask

  task automatic do_start(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic send_stream(input bit set_last, input bit toggle);
    int n;
    for (int i = 0; i < stim.size(); i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = set_last && (i == stim.size() - 1);
      n = 0;
      while (!in_ready && n < 20) begin step; n++; end
      if (!in_ready) begin
        vec++; miscompares++;
        $display("FAIL stream_ready byte %0d: in_ready=0 required 1", i);
        break;
      end
      step;
      if (toggle) begin in_valid = 1'b0; step; end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 100) begin step; n++; end
    vec++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%0b required 0 after 100 cycles", busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; base_addr = 32'h0;
    step; step;
    vec++;
    if ({in_ready, debug_en, debug_addr, debug_data_in, debug_write_en, cpu_hold,
         busy, done, error, err_code, word_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: some output nonzero (busy=%0b hold=%0b wc=%0d) required all 0",
               busy, cpu_hold, word_count);
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_basic_verify;
    logic [31:0] ea [2];
    logic [31:0] ed [2];
    ea[0] = 32'h0; ed[0] = 32'h00A00513;
    ea[1] = 32'h4; ed[1] = 32'h00100593;
    clear_log;
    do_start(32'h0);
    vec++;
    if ({busy, cpu_hold, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL basic_start_flags: busy/hold/done=%b required 110", {busy, cpu_hold, done});
    end
    stim = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_stream(1'b1, 1'b0);
    wait_idle;
    vec++;
    if (wa.size() != 2) begin
      miscompares++;
      $display("FAIL basic_write_count: %0d writes required 2", wa.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vec++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          miscompares++;
          $display("FAIL basic_write%0d: %h@%h required %h@%h", i, wd[i], wa[i], ed[i], ea[i]);
        end
      end
    end
    vec++;
    if ({done, error, cpu_hold, word_count} !== {3'b100, 16'd2}) begin
      miscompares++;
      $display("FAIL basic_status: done=%0b error=%0b hold=%0b wc=%0d required 1 0 0 2",
               done, error, cpu_hold, word_count);
    end
    vec++;
    if (mem[0] !== ed[0] || mem[1] !== ed[1]) begin
      miscompares++;
      $display("FAIL basic_mem: %h %h required %h %h", mem[0], mem[1], ed[0], ed[1]);
    end
  endtask

  task automatic test_partial_word;
    clear_log;
    do_start(32'h0);
    vec++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_done_cleared: done=%0b required 0", done);
    end
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_stream(1'b1, 1'b0);
    wait_idle;
    vec++;
    if (wa.size() != 2) begin
      miscompares++;
      $display("FAIL partial_write_count: %0d writes required 2", wa.size());
    end else begin
      vec++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h04030201 || wa[1] !== 32'h4 || wd[1] !== 32'h00000605) begin
        miscompares++;
        $display("FAIL partial_words: %h@%h %h@%h required 04030201@0 00000605@4",
                 wd[0], wa[0], wd[1], wa[1]);
      end
    end
    vec++;
    if ({done, error, word_count} !== {2'b10, 16'd2}) begin
      miscompares++;
      $display("FAIL partial_status: done=%0b error=%0b wc=%0d required 1 0 2", done, error, word_count);
    end
  endtask

  task automatic test_valid_toggle;
    clear_log;
    do_start(32'h0);
    stim = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_stream(1'b1, 1'b1);
    wait_idle;
    vec++;
    if (wa.size() != 2) begin
      miscompares++;
      $display("FAIL toggle_write_count: %0d writes required 2", wa.size());
    end else begin
      vec++;
      if (wd[0] !== 32'h00A00513 || wd[1] !== 32'h00100593 || wa[1] !== 32'h4) begin
        miscompares++;
        $display("FAIL toggle_words: %h %h@%h required 00A00513 00100593@4", wd[0], wd[1], wa[1]);
      end
      vec++;
      if (wacc[0] != 4 || wacc[1] != 8) begin
        miscompares++;
        $display("FAIL toggle_write_timing: writes after %0d,%0d bytes required 4,8", wacc[0], wacc[1]);
      end
    end
    vec++;
    if (mem[0] !== 32'h00A00513 || mem[1] !== 32'h00100593 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_mem: %h %h done=%0b required 00A00513 00100593 1", mem[0], mem[1], done);
    end
  endtask

  task automatic test_overflow;
    clear_log;
    do_start(32'h8);
    stim = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
             8'h19, 8'h1A, 8'h1B, 8'h1C};
    send_stream(1'b1, 1'b0);
    wait_idle;
    vec++;
    if (wa.size() != 2) begin
      miscompares++;
      $display("FAIL overflow_write_count: %0d writes required 2", wa.size());
    end else begin
      vec++;
      if (wa[0] !== 32'h8 || wd[0] !== 32'h14131211 || wa[1] !== 32'hC || wd[1] !== 32'h18171615) begin
        miscompares++;
        $display("FAIL overflow_words: %h@%h %h@%h required 14131211@8 18171615@c",
                 wd[0], wa[0], wd[1], wa[1]);
      end
    end
    vec++;
    if ({error, err_code, done, cpu_hold, word_count} !== {1'b1, 2'd2, 1'b0, 1'b1, 16'd2}) begin
      miscompares++;
      $display("FAIL overflow_status: error=%0b code=%0d done=%0b hold=%0b wc=%0d required 1 2 0 1 2",
               error, err_code, done, cpu_hold, word_count);
    end
  endtask

  task automatic test_verify_mismatch;
    clear_log;
    corrupt = 1'b1;
    do_start(32'h0);
    stim = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    send_stream(1'b0, 1'b0);
    wait_idle;
    corrupt = 1'b0;
    vec++;
    if (wa.size() != 2) begin
      miscompares++;
      $display("FAIL mismatch_write_count: %0d writes required 2", wa.size());
    end else begin
      vec++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'h28272625) begin
        miscompares++;
        $display("FAIL mismatch_second_write: %h@%h required 28272625@4", wd[1], wa[1]);
      end
    end
    vec++;
    if ({error, err_code, done, cpu_hold, word_count} !== {1'b1, 2'd1, 1'b0, 1'b1, 16'd2}) begin
      miscompares++;
      $display("FAIL mismatch_status: error=%0b code=%0d done=%0b hold=%0b wc=%0d required 1 1 0 1 2",
               error, err_code, done, cpu_hold, word_count);
    end
  endtask

  task automatic test_reset_mid_session;
    clear_log;
    do_start(32'h6);
    stim = '{8'hAA, 8'hBB};
    send_stream(1'b0, 1'b0);
    reset = 1'b1;
    step;
    vec++;
    if ({in_ready, debug_en, debug_addr, debug_data_in, debug_write_en, cpu_hold,
         busy, done, error, err_code, word_count} !== '0 || wa.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_outputs: busy=%0b hold=%0b ready=%0b writes=%0d required all 0",
               busy, cpu_hold, in_ready, wa.size());
    end
    reset = 1'b0;
    step;
    clear_log;
    do_start(32'h6);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(1'b1, 1'b0);
    wait_idle;
    vec++;
    if (wa.size() != 1) begin
      miscompares++;
      $display("FAIL reload_write_count: %0d writes required 1", wa.size());
    end else begin
      vec++;
      if (wa[0] !== 32'h4 || wd[0] !== 32'h44332211) begin
        miscompares++;
        $display("FAIL reload_word: %h@%h required 44332211@4", wd[0], wa[0]);
      end
    end
    vec++;
    if ({done, error, cpu_hold, word_count} !== {3'b100, 16'd1} || mem[1] !== 32'h44332211) begin
      miscompares++;
      $display("FAIL reload_status: done=%0b error=%0b hold=%0b wc=%0d mem1=%h required 1 0 0 1 44332211",
               done, error, cpu_hold, word_count, mem[1]);
    end
  endtask

  initial begin
    test_reset;
    test_basic_verify;
    test_partial_word;
    test_valid_toggle;
    test_overflow;
    test_verify_mismatch;
    test_reset_mid_session;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
